// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared definitions for the core reset sequencer.
//   seq_state_e  - sequencer FSM states (HOLD, ALIGN, RUN)
//   cnt_width()  - counter width helper that never returns zero
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } seq_state_e;

  // Width needed to count 0..n-1; at least one bit so n==1 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// debounce: button synchronizer plus stable-count debouncer.
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   btn_i    raw asynchronous button level
//   deb      debounced button level (registered)
//   press    strobe, true in the cycle deb is about to rise (from registered state)
module debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic deb,
  output logic press
);

  localparam int unsigned DCW = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic [DCW-1:0]         dcnt;
  logic                   s;
  logic                   done;

  assign s     = sync[SYNC_STAGES-1];
  assign done  = (s != deb) && (dcnt == DCW'(DEBOUNCE_CYCLES - 1));
  // Only debounced rises produce an event; releases just update deb.
  assign press = done & s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync <= '0;
      deb  <= 1'b0;
      dcnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_i};
      if (s == deb) begin
        dcnt <= '0;
      end else if (done) begin
        deb  <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: builds the core reset from the global reset and a debounced
// push-button, and releases it just after a core-clock falling edge.
//   clk_i         system clock
//   reset_i       synchronous active-high global reset (highest priority)
//   btn_i         raw asynchronous button, active-high
//   core_clk_i    divided core clock, sampled as data in the clk_i domain
//   core_reset_o  registered active-high reset to the core
//   ready_o       registered, high while the core is out of reset
//   btn_event_o   registered one-cycle pulse per debounced press
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_EDGES      = 16,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  input  logic core_clk_i,
  output logic core_reset_o,
  output logic ready_o,
  output logic btn_event_o
);

  localparam int unsigned ECW = $clog2(HOLD_EDGES + 1);

  seq_state_e     state;
  logic [ECW-1:0] ecnt;
  logic           cq;
  logic           rise;
  logic           fall;
  logic           press;
  logic           btn_level;

  debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debounce (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .btn_i   (btn_i),
    .deb     (btn_level),
    .press   (press)
  );

  assign rise = core_clk_i & ~cq;
  assign fall = ~core_clk_i & cq;

  // A press outranks any edge-driven transition in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= HOLD;
      ecnt         <= '0;
      cq           <= 1'b0;
      core_reset_o <= 1'b1;
      ready_o      <= 1'b0;
      btn_event_o  <= 1'b0;
    end else begin
      cq          <= core_clk_i;
      btn_event_o <= press;
      if (press) begin
        state        <= HOLD;
        ecnt         <= '0;
        core_reset_o <= 1'b1;
        ready_o      <= 1'b0;
      end else begin
        unique case (state)
          HOLD: begin
            if (rise) begin
              ecnt <= ecnt + 1'b1;
              if (ecnt == ECW'(HOLD_EDGES - 1)) state <= ALIGN;
            end
          end
          ALIGN: begin
            if (fall) begin
              state        <= RUN;
              core_reset_o <= 1'b0;
              ready_o      <= 1'b1;
            end
          end
          RUN: ;
          default: begin
            state        <= HOLD;
            ecnt         <= '0;
            core_reset_o <= 1'b1;
            ready_o      <= 1'b0;
          end
        endcase
      end
    end
  end

  // Every event coincides with the debounced level having just gone high.
  assert property (@(posedge clk_i) disable iff (reset_i) btn_event_o |-> btn_level);

endmodule
